// File: rtl/integral_image_pkg.sv
// integral_image_pkg: frame geometry and integral-image bus widths shared with the detector
package integral_image_pkg;
    localparam int II_WIDTH  = 160;
    localparam int II_HEIGHT = 120;
    localparam int II_AW     = 15;
    localparam int II_DW     = 21;
    typedef logic [II_AW-1:0] ii_addr_t;
    typedef logic [II_DW-1:0] ii_data_t;
endpackage

// File: rtl/integral_image_if.sv
// integral_image_if: pixel stream in, integral-image RAM writes and frame status out
interface integral_image_if
    import integral_image_pkg::*;
#(
    parameter int PIX_W = 4
);
    logic             frame_start;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             hold;
    logic             ii_wr_en;
    ii_addr_t         ii_wr_addr;
    ii_data_t         ii_wr_data;
    logic             busy;
    logic             frame_done;
    modport master (
        output frame_start, pix_valid, pix_data, hold,
        input  ii_wr_en, ii_wr_addr, ii_wr_data, busy, frame_done
    );
    modport slave (
        input  frame_start, pix_valid, pix_data, hold,
        output ii_wr_en, ii_wr_addr, ii_wr_data, busy, frame_done
    );
endinterface

// File: rtl/ii_line_buffer.sv
// ii_line_buffer: one row of integral values, async read, sync write, single port
module ii_line_buffer #(
    parameter int DEPTH = 160,
    parameter int DW    = 21,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/integral_image.sv
// integral_image: streaming integral image of a raster frame, one RAM write per accepted pixel
module integral_image #(
    parameter int II_WIDTH  = integral_image_pkg::II_WIDTH,
    parameter int II_HEIGHT = integral_image_pkg::II_HEIGHT,
    parameter int PIX_W     = 4
) (
    input logic               clk,
    input logic               rst,
    integral_image_if.slave   bus
);
    import integral_image_pkg::*;
    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    localparam int CW = $clog2(II_WIDTH);
    localparam int RW = $clog2(II_HEIGHT + 1);
    state_t         state, state_nxt;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [II_AW-1:0] idx;
    logic [II_DW-1:0] row_sum, row_sum_nxt, above, value, lb_rd;
    logic           restart, acc, last_col, last, wr_last;
    // wr_last marks the write cycle of the final pixel; no pixel is taken then
    always_comb begin
        restart     = bus.frame_start && (state == ACTIVE || (state == IDLE && !bus.hold));
        acc         = state == ACTIVE && bus.pix_valid && !bus.frame_start && !wr_last;
        last_col    = col == CW'(II_WIDTH - 1);
        last        = last_col && row == RW'(II_HEIGHT - 1);
        row_sum_nxt = row_sum + {{(II_DW-PIX_W){1'b0}}, bus.pix_data};
        above       = row == '0 ? '0 : lb_rd;
        value       = row_sum_nxt + above;
        state_nxt   = restart ? ACTIVE :
                      state == DONE ? IDLE :
                      (state == ACTIVE && wr_last) ? DONE : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_nxt;
    end
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            col     <= '0;
            row     <= '0;
            row_sum <= '0;
            idx     <= '0;
        end else if (acc) begin
            col     <= last_col ? '0 : col + 1'b1;
            row     <= last_col ? row + 1'b1 : row;
            row_sum <= last_col ? '0 : row_sum_nxt;
            idx     <= idx + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ii_wr_en   <= 1'b0;
            bus.ii_wr_addr <= '0;
            bus.ii_wr_data <= '0;
            wr_last        <= 1'b0;
        end else begin
            bus.ii_wr_en <= acc;
            wr_last      <= acc && last;
            if (acc) begin
                bus.ii_wr_addr <= idx;
                bus.ii_wr_data <= value;
            end
        end
    end
    assign bus.busy       = state == ACTIVE;
    assign bus.frame_done = state == DONE;
    ii_line_buffer #(.DEPTH(II_WIDTH), .DW(II_DW)) u_line (
        .clk   (clk),
        .we    (acc),
        .addr  (col),
        .wdata (value),
        .rdata (lb_rd)
    );
endmodule

// File: doc/integral_image.md
INTEGRAL_IMAGE -- requirements
Module: integral_image

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-002 Parameters, one per line, SHALL be: II_WIDTH, 160, image columns; II_HEIGHT, 120, image rows; PIX_W, 4, luma bits.
REQ-003 Ports, one per line, SHALL be:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse marking the start of a frame
- pix_valid  in  1  pix_data is valid this cycle
- pix_data  in  PIX_W  unsigned luma, raster order
- hold  in  1  detection is reading the RAM; new frames are refused
- ii_wr_en  out  1  integral-image RAM write strobe
- ii_wr_addr  out  15  row*II_WIDTH+col
- ii_wr_data  out  21  signed integral value, always non-negative
- busy  out  1  a frame is being accumulated
- frame_done  out  1  one-cycle pulse after the last write of a frame

Function
REQ-004 The block SHALL compute ii(x,y) = sum of pix over columns 0..x and rows 0..y, and SHALL write one value per accepted pixel.
REQ-005 The FSM states SHALL be IDLE, ACTIVE and DONE.
- IDLE -> ACTIVE on frame_start && !hold.
- ACTIVE -> DONE after the write of pixel (II_WIDTH-1, II_HEIGHT-1).
- DONE -> IDLE unconditionally after 1 cycle.
REQ-006 In IDLE and DONE, pix_valid SHALL be ignored.
REQ-007 In ACTIVE, each pix_valid cycle SHALL:
- compute row_sum_nxt = row_sum + pix_data;
- compute value = row_sum_nxt + above, where above = line_buf[col], and above = 0 on row 0;
- update line_buf[col] <= value.
REQ-008 Write latency SHALL be exactly 1 cycle: ii_wr_en=1 with ii_wr_addr and ii_wr_data registered in the cycle after the pixel is accepted.
REQ-009 ii_wr_en SHALL be 0 in every other cycle.
REQ-010 Column wrap: at col=II_WIDTH-1 the block SHALL set col to 0, clear row_sum to 0 and increment row.
REQ-011 Gaps in pix_valid SHALL stall the counters without penalty.
REQ-012 Arithmetic SHALL be unsigned internally, zero-extended to 21 bits. The maximum value is 15*19200 = 288000 < 2^20, so no saturation is needed.
REQ-013 A frame_start received in ACTIVE SHALL abort and restart the frame:
- col, row and row_sum return to 0;
- no frame_done pulse is issued;
- a pending write from the previous cycle still completes.
REQ-014 A frame_start coincident with pix_valid in IDLE SHALL NOT accept that pixel; the first pixel is taken on a later cycle.
REQ-015 busy SHALL be 1 in ACTIVE and 0 otherwise.
REQ-016 frame_done SHALL be 1 only in the DONE cycle, which is the cycle after the final write.
REQ-017 While hold=1 in IDLE, frame_start SHALL be dropped and not queued. hold SHALL have no effect in ACTIVE.

Reset
REQ-018 On rst the block SHALL set: state=IDLE, col=0, row=0, row_sum=0, ii_wr_en=0, ii_wr_addr=0, ii_wr_data=0, busy=0, frame_done=0.
REQ-019 line_buf contents SHALL NOT need a reset, because row 0 never reads it.
REQ-020 rst asserted mid-frame SHALL suppress any pending write in the next cycle.

Structure
REQ-021 II_WIDTH, II_HEIGHT, the 15-bit address width and the 21-bit data width SHALL live in a shared package also used by the cascade and classifiers.
REQ-022 The FSM state encoding SHALL be local to the block.
REQ-023 The line buffer SHALL be a sub-module, ii_line_buffer: II_WIDTH x 21-bit, asynchronous read, synchronous write, one port.

Verification
REQ-024 Flat frame: all pix=1 -> ii at addr 0 = 1, at 159 = 160, at 160 = 2, at 19199 = 19200; frame_done exactly one cycle after the write of addr 19199.
REQ-025 Max frame: all pix=15 -> last write data = 288000, with bit 20 = 0.
REQ-026 Stalls: pix_valid toggling 1,0,0,1 over a ramp frame -> results identical to a continuous frame; writes occur 1 cycle after each valid.
REQ-027 Abort: frame_start after 500 pixels -> the next write is to addr 0 with data equal to that frame's first pixel; frame_done appears only after 19200 further pixels.
REQ-028 Hold: frame_start with hold=1 -> busy stays 0 and no writes occur; frame_start with hold=0 one cycle later -> busy=1.
REQ-029 Reset mid-frame: rst at pixel 1000 -> ii_wr_en=0 the next cycle, all outputs at reset values, and pixels are ignored until a new frame_start.
